// File: rtl/dmem_ctrl_rv32_if.sv
// Request, response and data-memory bus bundle for dmem_ctrl_rv32.
// master = controller side, slave = MA stage plus memory side.
interface dmem_ctrl_rv32_if;
    logic        iReqVALID;
    logic [4:0]  iReqOP;
    logic [31:0] iReqADDR;
    logic [31:0] iReqWDATA;
    logic        oStall;
    logic [31:0] oLoadDATA;
    logic        oLoadVALID;
    logic        oStoreDONE;
    logic        oBusERR;
    logic        oMisalign;
    logic        oMemREQ;
    logic        oMemWE;
    logic [3:0]  oMemBE;
    logic [31:0] oMemADDR;
    logic [31:0] oMemWDATA;
    logic        iMemACK;
    logic [31:0] iMemRDATA;

    modport master (
        input  iReqVALID, iReqOP, iReqADDR, iReqWDATA,
        input  iMemACK, iMemRDATA,
        output oStall, oLoadDATA, oLoadVALID, oStoreDONE,
        output oBusERR, oMisalign,
        output oMemREQ, oMemWE, oMemBE, oMemADDR, oMemWDATA
    );

    modport slave (
        output iReqVALID, iReqOP, iReqADDR, iReqWDATA,
        output iMemACK, iMemRDATA,
        input  oStall, oLoadDATA, oLoadVALID, oStoreDONE,
        input  oBusERR, oMisalign,
        input  oMemREQ, oMemWE, oMemBE, oMemADDR, oMemWDATA
    );
endinterface

// File: rtl/dmem_ctrl_rv32.sv
// RV32I data-memory access controller (IDLE/BUSY/RESP req/ack FSM).
// Define DMEM_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses.
module dmem_ctrl_rv32 #(
    parameter int TIMEOUT = 16
) (
    input logic              iCLK,
    input logic              iRSTn,
    dmem_ctrl_rv32_if.master bus
);

    localparam logic [4:0] OP_LB  = 5'd1;
    localparam logic [4:0] OP_LH  = 5'd2;
    localparam logic [4:0] OP_LW  = 5'd3;
    localparam logic [4:0] OP_LBU = 5'd4;
    localparam logic [4:0] OP_LHU = 5'd5;
    localparam logic [4:0] OP_SB  = 5'd6;
    localparam logic [4:0] OP_SH  = 5'd7;
    localparam logic [4:0] OP_SW  = 5'd8;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic        uns_q, uns_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic [3:0]  be_q, be_d;
    logic [29:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        mis_q, mis_d;

    logic        req_mem, req_ld, req_uns, req_mis;
    logic [1:0]  req_size, req_off, a;
    logic [3:0]  req_be;
    logic [31:0] req_wd;
    logic        req_go, req_trap;
    logic [31:0] sh, ld;
    logic        ld_valid;

    // Decode the MA-stage operation into access kind and size
    always_comb begin
        req_mem  = 1'b1;
        req_ld   = 1'b0;
        req_uns  = 1'b0;
        req_size = SZ_W;
        case (bus.iReqOP)
            OP_LB:  begin req_ld = 1'b1; req_size = SZ_B; end
            OP_LH:  begin req_ld = 1'b1; req_size = SZ_H; end
            OP_LW:  req_ld = 1'b1;
            OP_LBU: begin req_ld = 1'b1; req_uns = 1'b1; req_size = SZ_B; end
            OP_LHU: begin req_ld = 1'b1; req_uns = 1'b1; req_size = SZ_H; end
            OP_SB:  req_size = SZ_B;
            OP_SH:  req_size = SZ_H;
            OP_SW:  req_size = SZ_W;
            default: req_mem = 1'b0;
        endcase
    end

    // Lane offset, byte enables and replicated store data
    always_comb begin
        a       = bus.iReqADDR[1:0];
        req_mis = ((req_size == SZ_H) && a[0]) ||
                  ((req_size == SZ_W) && (a != 2'b00));
        req_off = 2'b00;
        req_be  = 4'b1111;
        req_wd  = bus.iReqWDATA;
        unique case (1'b1)
            (req_size == SZ_B): begin
                req_off = a;
                req_be  = 4'b0001 << a;
                req_wd  = {4{bus.iReqWDATA[7:0]}};
            end
            (req_size == SZ_H): begin
                req_off = {a[1], 1'b0};
                req_be  = a[1] ? 4'b1100 : 4'b0011;
                req_wd  = {2{bus.iReqWDATA[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    assign req_go   = bus.iReqVALID & req_mem & ~req_mis;
    assign req_trap = bus.iReqVALID & req_mem & req_mis;
`else
    // Misaligned accesses are issued with the low address bits dropped
    assign req_go   = bus.iReqVALID & req_mem;
    assign req_trap = 1'b0;
`endif

    // Next-state and register-load logic of the transaction FSM
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        uns_d   = uns_q;
        size_d  = size_q;
        off_d   = off_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        mis_d   = 1'b0;
        case (state_q)
            IDLE: begin
                mis_d = req_trap;
                if (req_go) begin
                    we_d    = ~req_ld;
                    uns_d   = req_uns;
                    size_d  = req_size;
                    off_d   = req_off;
                    be_d    = req_be;
                    addr_d  = bus.iReqADDR[31:2];
                    wdata_d = req_wd;
                    cnt_d   = 8'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (bus.iMemACK) begin
                    rdata_d = bus.iMemRDATA;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and transaction registers
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= SZ_B;
            off_q   <= 2'b00;
            be_q    <= 4'b0000;
            addr_q  <= 30'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            size_q  <= size_d;
            off_q   <= off_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            mis_q   <= mis_d;
        end
    end

    // Lane select and sign/zero extension of the captured read word
    always_comb begin
        sh = rdata_q >> {off_q, 3'b000};
        ld = rdata_q;
        unique case (1'b1)
            (size_q == SZ_B):
                ld = uns_q ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            (size_q == SZ_H):
                ld = uns_q ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: ;
        endcase
    end

    assign ld_valid       = (state_q == RESP) & ~we_q;
    assign bus.oLoadVALID = ld_valid;
    assign bus.oLoadDATA  = ld_valid ? ld : 32'd0;
    assign bus.oStoreDONE = (state_q == RESP) & we_q;
    assign bus.oStall     = ((state_q == IDLE) & req_go) | (state_q == BUSY);
    assign bus.oMemREQ    = (state_q == BUSY);
    assign bus.oMemWE     = we_q;
    assign bus.oMemBE     = be_q;
    assign bus.oMemADDR   = {addr_q, 2'b00};
    assign bus.oMemWDATA  = wdata_q;
    assign bus.oBusERR    = err_q;
    assign bus.oMisalign  = mis_q;

endmodule

// File: tb/tb_dmem_ctrl_rv32.sv
// Randomized bench for dmem_ctrl_rv32 with a transaction-level model.
// Two instances: TIMEOUT=16 (wait states) and TIMEOUT=4 (timeouts).
module tb_dmem_ctrl_rv32;

    localparam logic [4:0] LB  = 5'd1;
    localparam logic [4:0] LH  = 5'd2;
    localparam logic [4:0] LW  = 5'd3;
    localparam logic [4:0] LBU = 5'd4;
    localparam logic [4:0] LHU = 5'd5;
    localparam logic [4:0] SB  = 5'd6;
    localparam logic [4:0] SH  = 5'd7;
    localparam logic [4:0] SW  = 5'd8;

    typedef struct packed {
        logic        stall, req, we;
        logic [3:0]  be;
        logic [31:0] addr, wdata, ldata;
        logic        lv, sd, err, mis;
    } outs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    logic        d_valid[2];
    logic [4:0]  d_op[2];
    logic [31:0] d_addr[2], d_wd[2], d_rd[2];
    logic        d_ack[2];

    bit          m_act[2];
    int          m_t0[2], m_d[2];
    logic [4:0]  m_op[2];
    logic [31:0] m_addr[2], m_wd[2], m_rd[2];

    dmem_ctrl_rv32_if bus0();
    dmem_ctrl_rv32_if bus1();

    assign bus0.iReqVALID = d_valid[0];
    assign bus0.iReqOP    = d_op[0];
    assign bus0.iReqADDR  = d_addr[0];
    assign bus0.iReqWDATA = d_wd[0];
    assign bus0.iMemACK   = d_ack[0];
    assign bus0.iMemRDATA = d_rd[0];
    assign bus1.iReqVALID = d_valid[1];
    assign bus1.iReqOP    = d_op[1];
    assign bus1.iReqADDR  = d_addr[1];
    assign bus1.iReqWDATA = d_wd[1];
    assign bus1.iMemACK   = d_ack[1];
    assign bus1.iMemRDATA = d_rd[1];

    dmem_ctrl_rv32 #(.TIMEOUT(16)) u0 (
        .iCLK(clk), .iRSTn(rst_n), .bus(bus0)
    );
    dmem_ctrl_rv32 #(.TIMEOUT(4)) u1 (
        .iCLK(clk), .iRSTn(rst_n), .bus(bus1)
    );

    always @(posedge clk) cyc <= cyc + 1;

    function automatic outs_t get(input int i);
        outs_t o;
        if (i == 0)
            o = '{bus0.oStall, bus0.oMemREQ, bus0.oMemWE, bus0.oMemBE,
                  bus0.oMemADDR, bus0.oMemWDATA, bus0.oLoadDATA,
                  bus0.oLoadVALID, bus0.oStoreDONE, bus0.oBusERR,
                  bus0.oMisalign};
        else
            o = '{bus1.oStall, bus1.oMemREQ, bus1.oMemWE, bus1.oMemBE,
                  bus1.oMemADDR, bus1.oMemWDATA, bus1.oLoadDATA,
                  bus1.oLoadVALID, bus1.oStoreDONE, bus1.oBusERR,
                  bus1.oMisalign};
        return o;
    endfunction

    task automatic chk(input string nm, input int i,
                       input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s u%0d cyc=%0d got=%h exp=%h",
                     nm, i, cyc, act, exp);
        end
    endtask

    // ---- reference model: rules in plain arithmetic ----
    function automatic int tmo(input int i);
        return (i == 0) ? 16 : 4;
    endfunction

    function automatic int szof(input logic [4:0] op);
        if (op == LB || op == LBU || op == SB) return 0;
        if (op == LH || op == LHU || op == SH) return 1;
        if (op == LW || op == SW) return 2;
        return 3;
    endfunction

    function automatic bit isld(input logic [4:0] op);
        return op inside {LB, LH, LW, LBU, LHU};
    endfunction

    function automatic bit trapped(input logic [4:0] op,
                                   input logic [31:0] a);
`ifdef DMEM_MISALIGN_TRAP_EN
        return (szof(op) == 1 && a[0]) ||
               (szof(op) == 2 && a % 4 != 0);
`else
        return (op == 5'd31) && (a == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    function automatic bit okd(input int i);
        return m_d[i] >= 1 && m_d[i] <= tmo(i);
    endfunction

    function automatic int endrel(input int i);
        if (trapped(m_op[i], m_addr[i])) return 1;
        return okd(i) ? m_d[i] + 1 : tmo(i) + 1;
    endfunction

    function automatic logic [3:0] exp_be(input logic [4:0] op,
                                          input logic [31:0] a);
        int s = szof(op);
        if (s == 0) return 4'(1 << (a % 4));
        if (s == 1) return ((a % 4) >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] exp_wd(input logic [4:0] op,
                                           input logic [31:0] wd);
        int s = szof(op);
        if (s == 0) return (wd & 32'hFF) * 32'h0101_0101;
        if (s == 1) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] exp_ld(input logic [4:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] rd);
        int off;
        logic [31:0] v;
        off = (szof(op) == 0) ? int'(a % 4) :
              (szof(op) == 1) ? int'(a % 4) / 2 * 2 : 0;
        v = rd >> (8 * off);
        case (op)
            LB:  return (v & 32'h80) != 0 ? (v | 32'hFFFF_FF00)
                                          : (v & 32'hFF);
            LBU: return v & 32'hFF;
            LH:  return (v & 32'h8000) != 0 ? (v | 32'hFFFF_0000)
                                            : (v & 32'hFFFF);
            LHU: return v & 32'hFFFF;
            default: return rd;
        endcase
    endfunction

    // Per-cycle comparison of both instances against the model
    task automatic cmp(input int i);
        outs_t o;
        int r, e;
        bit act, trap, ld, ok;
        o = get(i);
        r = cyc - m_t0[i];
        e = endrel(i);
        act = m_act[i] && r >= 0 && r <= e;
        trap = trapped(m_op[i], m_addr[i]);
        ld = isld(m_op[i]);
        ok = okd(i);
        chk("stall", i, 32'(o.stall), 32'(act && !trap && r < e));
        chk("req", i, 32'(o.req), 32'(act && !trap && r >= 1 && r < e));
        chk("ldvalid", i, 32'(o.lv), 32'(act && !trap && ok && ld && r == e));
        chk("stdone", i, 32'(o.sd), 32'(act && !trap && ok && !ld && r == e));
        chk("buserr", i, 32'(o.err), 32'(act && !trap && !ok && r == e));
        chk("misalign", i, 32'(o.mis), 32'(act && trap && r == 1));
        if (act && !trap && r >= 1 && r < e) begin
            chk("we", i, 32'(o.we), 32'(!ld));
            chk("be", i, 32'(o.be), 32'(exp_be(m_op[i], m_addr[i])));
            chk("addr", i, o.addr, m_addr[i] & ~32'd3);
            if (!ld) chk("wdata", i, o.wdata, exp_wd(m_op[i], m_wd[i]));
        end
        if (act && !trap && ok && ld && r == e)
            chk("ldata", i, o.ldata, exp_ld(m_op[i], m_addr[i], m_rd[i]));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp(0);
            cmp(1);
        end
    end

    function automatic logic [4:0] nonmem();
        int v = $urandom_range(9, 32);
        return (v == 32) ? 5'd0 : 5'(v);
    endfunction

    // One instruction: accept cycle, wait states, completion cycle
    task automatic txn(input int i, input logic [4:0] op,
                       input logic [31:0] a, wd, rd, input int d,
                       input bit rv, input bit lit, input logic [3:0] lbe,
                       input logic [31:0] laddr, lwd, lld);
        int e;
        bit trap, ok;
        outs_t o;
        @(posedge clk); #1;
        m_t0[i] = cyc; m_op[i] = op; m_addr[i] = a;
        m_wd[i] = wd; m_rd[i] = rd; m_d[i] = d; m_act[i] = 1'b1;
        d_valid[i] = 1'b1; d_op[i] = op; d_addr[i] = a; d_wd[i] = wd;
        d_ack[i] = 1'($urandom_range(0, 1)); d_rd[i] = $urandom;
        e = endrel(i);
        trap = trapped(op, a);
        ok = okd(i);
        for (int r = 1; r <= e; r++) begin
            @(posedge clk); #1;
            d_ack[i] = (r == d) ? 1'b1 :
                       (r == e) ? 1'($urandom_range(0, 1)) : 1'b0;
            d_rd[i] = (r == d) ? rd : $urandom;
            d_op[i] = 5'($urandom);
            d_addr[i] = $urandom;
            d_wd[i] = $urandom;
            d_valid[i] = (r < e) ? 1'b1 : (rv && ok && !trap);
            if (lit && r == 1) begin
                @(negedge clk);
                o = get(i);
                if (trap) begin
                    chk("lit_mis", i, 32'(o.mis), 32'd1);
                    chk("lit_noreq", i, 32'(o.req), 32'd0);
                end else begin
                    chk("lit_be", i, 32'(o.be), 32'(lbe));
                    chk("lit_addr", i, o.addr, laddr);
                    if (!isld(op)) chk("lit_wd", i, o.wdata, lwd);
                end
            end
            if (lit && r == e && !trap && isld(op)) begin
                @(negedge clk);
                o = get(i);
                chk("lit_ld", i, o.ldata, lld);
            end
        end
    endtask

    task automatic idle(input int i, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            m_act[i] = 1'b0;
            d_valid[i] = 1'($urandom_range(0, 1));
            d_op[i] = nonmem();
            d_addr[i] = $urandom;
            d_ack[i] = 1'($urandom_range(0, 1));
            d_rd[i] = $urandom;
        end
    endtask

    task automatic rnd(input int i, input int n);
        logic [4:0] op;
        for (int k = 0; k < n; k++) begin
            op = 5'($urandom_range(1, 8));
            txn(i, op, $urandom, $urandom, $urandom,
                $urandom_range(0, tmo(i) + 2), 1'($urandom_range(0, 1)),
                1'b0, 4'h0, 32'd0, 32'd0, 32'd0);
            if ($urandom_range(0, 2) == 0) idle(i, $urandom_range(1, 3));
        end
    endtask

    task automatic flow0();
        logic [31:0] rdv;
        rdv = 32'h80FF_7F01;
        txn(0, LW, 32'h100, 32'h0, 32'hCAFE_F00D, 1, 0, 1,
            4'hF, 32'h100, 32'h0, 32'hCAFE_F00D);
        txn(0, SB, 32'h203, 32'hA5, 32'h0, 2, 1, 1,
            4'b1000, 32'h200, 32'hA5A5_A5A5, 32'h0);
        txn(0, SH, 32'h202, 32'h1234, 32'h0, 1, 0, 1,
            4'b1100, 32'h200, 32'h1234_1234, 32'h0);
        txn(0, LB, 32'h103, 32'h0, rdv, 1, 1, 1,
            4'b1000, 32'h100, 32'h0, 32'hFFFF_FF80);
        txn(0, LBU, 32'h103, 32'h0, rdv, 2, 0, 1,
            4'b1000, 32'h100, 32'h0, 32'h0000_0080);
        txn(0, LH, 32'h102, 32'h0, rdv, 1, 0, 1,
            4'b1100, 32'h100, 32'h0, 32'hFFFF_80FF);
        txn(0, LHU, 32'h100, 32'h0, rdv, 3, 0, 1,
            4'b0011, 32'h100, 32'h0, 32'h0000_7F01);
        idle(0, 2);
        txn(0, LW, 32'h40, 32'h0, 32'h1357_9BDF, 5, 0, 0,
            4'h0, 32'h0, 32'h0, 32'h0);
        idle(0, 1);
        txn(0, LW, 32'h102, 32'h0, 32'h2468_ACE0, 1, 0, 1,
            4'hF, 32'h100, 32'h0, 32'h2468_ACE0);
        idle(0, 1);
        txn(0, SW, 32'h300, 32'hDEAD_BEEF, 32'h0, 1, 1, 1,
            4'hF, 32'h300, 32'hDEAD_BEEF, 32'h0);
        txn(0, LW, 32'h304, 32'h0, 32'h0BAD_F00D, 1, 1, 0,
            4'h0, 32'h0, 32'h0, 32'h0);
        idle(0, 3);
        rnd(0, 150);
    endtask

    task automatic flow1();
        txn(1, LW, 32'h10, 32'h0, 32'h1111_2222, 0, 0, 0,
            4'h0, 32'h0, 32'h0, 32'h0);
        txn(1, SW, 32'h20, 32'h5555_AAAA, 32'h0, 4, 1, 1,
            4'hF, 32'h20, 32'h5555_AAAA, 32'h0);
        txn(1, LH, 32'h32, 32'h0, 32'h7777_8888, 5, 0, 0,
            4'h0, 32'h0, 32'h0, 32'h0);
        idle(1, 2);
        rnd(1, 200);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            d_valid[i] = 1'b0; d_op[i] = 5'd0; d_addr[i] = 32'd0;
            d_wd[i] = 32'd0; d_rd[i] = 32'd0; d_ack[i] = 1'b0;
            m_act[i] = 1'b0; m_t0[i] = 0; m_d[i] = 0; m_op[i] = 5'd0;
            m_addr[i] = 32'd0; m_wd[i] = 32'd0; m_rd[i] = 32'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs", 0, 32'(get(0) != '0), 32'd0);
        chk("rst_outs", 1, 32'(get(1) != '0), 32'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            m_t0[i] = cyc; m_op[i] = LW; m_addr[i] = 32'h100;
            m_d[i] = 0; m_act[i] = 1'b1;
            d_valid[i] = 1'b1; d_op[i] = LW; d_addr[i] = 32'h100;
        end
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        chk_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 1'b0;
            d_valid[i] = 1'b0;
        end
        #1;
        chk("rst_mid_req", 0, 32'(get(0).req), 32'd0);
        chk("rst_mid_req", 1, 32'(get(1).req), 32'd0);
        chk("rst_mid_outs", 0, 32'(get(0) != '0), 32'd0);
        chk("rst_mid_outs", 1, 32'(get(1) != '0), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk_en = 1'b1;
        fork
            flow0();
            flow1();
        join
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dmem_ctrl_rv32.md
# dmem_ctrl_rv32

Data-memory access controller for the RV32I Memory Access stage. It takes one load/store request per instruction from the MA stage and runs a request/acknowledge transaction on the data-memory bus. It generates word address, byte enables and lane-replicated store data, and returns sign- or zero-extended load data. It stalls the pipeline while a transaction is outstanding and reports bus timeouts and misaligned accesses.

## Interface
- TIMEOUT, 16, number of BUSY cycles without iMemACK before the transaction is aborted (1..255)
- iCLK  in  1  clock, all state updates on rising edge
- iRSTn  in  1  reset; asynchronous assert, active-low
- iReqVALID  in  1  MA stage presents a memory instruction this cycle
- iReqOP  in  5  decoded operation: `LB, `LH, `LW, `LBU, `LHU, `SB, `SH, `SW from DecodedOP.vh
- iReqADDR  in  32  effective byte address
- iReqWDATA  in  32  store source register value (LSBs significant for SB/SH)
- oStall  out  1  hold pipeline
- oLoadDATA  out  32  extended load result
- oLoadVALID  out  1  one-cycle pulse, oLoadDATA valid
- oStoreDONE  out  1  one-cycle pulse, store acknowledged
- oBusERR  out  1  one-cycle pulse, transaction timed out
- oMisalign  out  1  one-cycle pulse, misaligned request rejected (macro only)
- oMemREQ  out  1  bus request, held until acknowledged
- oMemWE  out  1  1 = write, 0 = read
- oMemBE  out  4  byte enables
- oMemADDR  out  32  word address, {iReqADDR[31:2], 2'b00}
- oMemWDATA  out  32  lane-replicated store data
- iMemACK  in  1  bus acknowledge, sampled only in BUSY
- iMemRDATA  in  32  read word, valid with iMemACK

## Operation
- States: IDLE, BUSY, RESP. Timeout counter is 8 bits wide.
- Reset values: state IDLE, counter 0, every output 0.
- IDLE:
  - iReqVALID with a memory op is accepted: register op, offset, BE, address and WDATA, then go to BUSY.
  - iReqVALID with a non-memory op is ignored, and oStall stays 0.
- BUSY:
  - oMemREQ = 1; bus outputs stay stable.
  - iMemACK = 1: capture iMemRDATA and go to RESP.
  - Otherwise, counter == TIMEOUT-1: pulse oBusERR, drop oMemREQ, go to IDLE.
- RESP:
  - A load pulses oLoadVALID; a store pulses oStoreDONE. Then go to IDLE.
  - iReqVALID is ignored here, because it belongs to the same instruction.
- oStall = (IDLE & iReqVALID & memory op & aligned) | BUSY. It is combinational and is 0 in RESP.
- Byte enables and store data:
  - SB/LB/LBU: BE = 4'b0001 << addr[1:0]; WDATA = {4{wdata[7:0]}}.
  - SH/LH/LHU: BE = addr[1] ? 4'b1100 : 4'b0011; WDATA = {2{wdata[15:0]}}.
  - SW/LW: BE = 4'b1111.
- Load extraction:
  - Select the byte/halfword lane by the registered offset.
  - LB/LH sign-extend from bit 7/15. LBU/LHU zero-extend. LW passes the word through.
- iMemACK outside BUSY is ignored.
- An iMemACK in the timeout cycle wins: the transaction completes normally and there is no oBusERR.
- Asynchronous reset mid-transaction drops oMemREQ immediately and discards the request; no completion pulse follows.

## Timing
- Accept in cycle 0. oMemREQ is high from cycle 1.
- With iMemACK in cycle k (k ≥ 1), the completion pulse is in cycle k+1.
- Minimum load latency is 2 cycles; the pipeline sees oStall for cycles 0..k.
- Timeout: oBusERR in cycle TIMEOUT+1 after acceptance; oStall is 0 in that cycle.
- Back-to-back requests: the next request can be accepted in the cycle after RESP.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined:
  - A halfword with addr[0]=1, or a word with addr[1:0]≠0, is not issued. oStall stays 0.
  - oMisalign pulses in the following cycle, and the FSM stays IDLE.
- Undefined:
  - oMisalign is tied to 0.
  - Misaligned halfwords are issued with addr[0] forced to 0; misaligned words with addr[1:0] forced to 0.

## Test plan
- Reset:
  - Assert iRSTn=0 in BUSY -> oMemREQ=0 immediately; all outputs 0.
  - After release, LW at 0x100 with ACK in cycle 1 -> oMemADDR=0x100, BE=1111, and oLoadDATA=iMemRDATA with oLoadVALID in cycle 2.
- Store lanes:
  - SB addr 0x203, wdata 0x000000A5 -> BE=1000, WDATA=0xA5A5A5A5, oStoreDONE after ACK.
  - SH addr 0x202, wdata 0x1234 -> BE=1100, WDATA=0x12341234.
- Load extension, with rdata=0x80FF7F01:
  - LB @+3 -> 0xFFFFFF80.
  - LBU @+3 -> 0x00000080.
  - LH @+2 -> 0xFFFF80FF.
  - LHU @+0 -> 0x00007F01.
- Wait states and timeout:
  - ACK delayed 5 cycles -> oStall high for 6 cycles, and bus outputs stable throughout.
  - With TIMEOUT=4 and no ACK -> oBusERR pulse, then IDLE.
  - With TIMEOUT=4 and ACK in the final BUSY cycle -> normal completion, no oBusERR.
- Misalign:
  - Macro on, LW at 0x102 -> no oMemREQ, oStall=0, oMisalign pulse.
  - Macro off, LW at 0x102 -> oMemADDR=0x100, BE=1111.
- Back-to-back:
  - SW then LW on consecutive instructions with immediate ACK -> second oMemREQ rises 3 cycles after the first.
  - The iReqVALID seen during RESP is not re-accepted.
